hex_scan_ctrl: RTL and testbench
================================

# hex_scan_ctrl

Time-multiplexing scheduler for the board's 4-digit common 7-segment display. It shares the single 8-bit segment bus among four digit enables in round-robin slots. A blanking gap between slots suppresses ghosting. Shown data is double-buffered behind a load/ack handshake and changes only at frame boundaries. Outputs are active-high; the top level inverts them onto HEX_EN/HEX_LED, the same way it handles the other active-low board I/O.

## Interface

- SLOT_CYCLES, 50000: clock cycles a digit is lit per slot (1 ms at 50 MHz); must be ≥ 1.
- BLANK_CYCLES, 2500: clock cycles all digits are dark before each lit phase; must be ≥ 1.
- clock  in  1  system clock (50 MHz); all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  1 = scan; 0 = display dark, scheduler idle.
- value  in  16  four hex nibbles; value[3:0] = digit 0 (rightmost, hex_en[0]).
- dp  in  4  decimal point per digit; dp[i] belongs to digit i.
- blank_lz  in  1  1 = blank leading zeros.
- load  in  1  level request to capture value/dp/blank_lz into the shadow registers; held until load_ack.
- load_ack  out  1  one-cycle pulse in the cycle the capture occurs.
- hex_en  out  4  one-hot digit enable; all zero during blank, idle or a blanked digit.
- hex_led  out  8  segments: [0]=A … [6]=G, [7]=DP.
- frame_start  out  1  one-cycle pulse on the first blank cycle of digit 0.

## Operation

- FSM states:
  - IDLE: outputs dark.
  - BLANK: dark for BLANK_CYCLES.
  - ON: digit lit for SLOT_CYCLES.
- Transitions:
  - IDLE→BLANK(digit 0) when enable=1.
  - BLANK→ON when the cycle counter reaches BLANK_CYCLES-1.
  - ON→BLANK(digit+1 mod 4) when the counter reaches SLOT_CYCLES-1. The digit index wraps 3→0 and starts a new frame.
  - Any state→IDLE when enable=0. Digit index and counter clear.
- Frame length: 4·(BLANK_CYCLES+SLOT_CYCLES) cycles.
- Shadow capture occurs in a cycle where load=1 and either:
  - state is IDLE, or
  - the FSM is in the first BLANK cycle of digit 0 (same cycle as frame_start).
- On capture, load_ack=1 for that cycle only. A load held over several frames is captured once per qualifying cycle. The requester drops load after the ack.
- Data shown always comes from the shadow registers, never directly from value/dp/blank_lz.
- Decode (segments gfedcba, hex_led[6:0]): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71. hex_led[7]=dp[digit].
- Leading-zero blanking: with shadow blank_lz=1, digit i∈{3,2,1} is blanked if its nibble and all higher nibbles are 0. Digit 0 is never blanked. For a blanked digit, hex_en=0 and hex_led=0 for its ON phase, dp included.

## Timing

- All outputs are registered. Reset values:
  - hex_en=0, hex_led=0, load_ack=0, frame_start=0.
  - State IDLE, digit 0, counter 0.
  - Shadow value=0, dp=0, blank_lz=0.
- Reset is asynchronous. Asserting it mid-scan forces the reset values immediately. After release, operation resumes from IDLE.
- With enable=1 already held when reset releases:
  - First rising edge: BLANK, digit 0, frame_start=1.
  - First edge of digit 0's ON phase: BLANK_CYCLES edges after that.
- enable falling is sampled at an edge; the next edge puts the FSM in IDLE with all outputs 0. No partial slot completes.
- load and frame boundary in the same cycle: capture happens. The newly captured data is shown starting with that frame's digit 0 ON phase.
- hex_en and hex_led change together on the same edge. No cycle has hex_en≠0 with stale segments.

## Test plan

- SLOT_CYCLES=8, BLANK_CYCLES=2, enable=1, load value=0x1234, dp=0 → frame_start every 40 cycles; per frame:
  - hex_en 0001 / 0010 / 0100 / 1000, each for 8 cycles, separated by 2 dark cycles.
  - hex_led 4→66, 3→4F, 2→5B, 1→06.
- Load 0x00A0 with blank_lz=1, dp=4'b0100 → digits 0–1 show 3F, 77; digits 2–3 dark with hex_en=0 (dp suppressed on blanked digit 2).
- Mid-frame load of 0xFFFF → load_ack not seen until the next frame_start cycle. Old value is displayed until then; from the next digit 0 ON phase all digits show 71.
- enable dropped during a digit 2 ON phase → next edge hex_en=0, hex_led=0, state IDLE. Re-enable → frame_start on the next edge, scan restarts at digit 0.
- Async reset pulse between clock edges mid-slot → outputs 0 immediately, without waiting for an edge. Shadow value reads back 0 (digit 0 shows 3F) after the next load-free frame.
- Load with enable=0 → load_ack on the next edge. Display stays dark until enable=1.

Source files
------------

// File: rtl/hex_scan_ctrl.sv
// rtl/hex_scan_ctrl.sv - 4-digit 7-segment scan scheduler with blanking gaps and frame-aligned shadow data
module hex_scan_ctrl #(
  parameter int SLOT_CYCLES  = 50000,
  parameter int BLANK_CYCLES = 2500
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_enable,
  input  logic [15:0] i_value,
  input  logic [3:0]  i_dp,
  input  logic        i_blank_lz,
  input  logic        i_load,
  output logic        o_load_ack,
  output logic [3:0]  o_hex_en,
  output logic [7:0]  o_hex_led,
  output logic        o_frame_start
);

  localparam int MAX_CYCLES = (SLOT_CYCLES > BLANK_CYCLES) ? SLOT_CYCLES : BLANK_CYCLES;
  localparam int CW = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CW-1:0] SLOT_LAST  = CW'(SLOT_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BLANK = 2'd1;
  localparam logic [1:0] ST_ON    = 2'd2;

  logic [1:0]    r_state;
  logic [1:0]    r_digit;
  logic [CW-1:0] r_cnt;
  logic [15:0]   r_sh_value;
  logic [3:0]    r_sh_dp;
  logic          r_sh_lz;

  logic [1:0]    w_state;
  logic [1:0]    w_digit;
  logic [CW-1:0] w_cnt;
  logic          w_frame_start;
  logic          w_capture;
  logic [3:0]    w_nibble;
  logic [6:0]    w_seg;
  logic          w_lz_blank;
  logic [3:0]    w_hex_en;
  logic [7:0]    w_hex_led;

  always_comb begin
    w_state = ST_IDLE;
    w_digit = 2'd0;
    w_cnt   = '0;
    if (i_enable) begin
      case (r_state)
        ST_IDLE: begin
          w_state = ST_BLANK;
        end
        ST_BLANK: begin
          w_digit = r_digit;
          if (r_cnt == BLANK_LAST) begin
            w_state = ST_ON;
          end else begin
            w_state = ST_BLANK;
            w_cnt   = r_cnt + CW'(1);
          end
        end
        ST_ON: begin
          if (r_cnt == SLOT_LAST) begin
            w_state = ST_BLANK;
            w_digit = r_digit + 2'd1;
          end else begin
            w_state = ST_ON;
            w_digit = r_digit;
            w_cnt   = r_cnt + CW'(1);
          end
        end
        default: w_state = ST_IDLE;
      endcase
    end
  end

  // Outputs are registered from the next state, so decisions here use w_*.
  assign w_frame_start = (w_state == ST_BLANK) && (w_digit == 2'd0) && (w_cnt == '0);
  assign w_capture     = i_load && ((w_state == ST_IDLE) || w_frame_start);

  assign w_nibble = r_sh_value[{w_digit, 2'b00} +: 4];

  always_comb begin
    w_seg = 7'h00;
    case (w_nibble)
      4'h0: w_seg = 7'h3F;
      4'h1: w_seg = 7'h06;
      4'h2: w_seg = 7'h5B;
      4'h3: w_seg = 7'h4F;
      4'h4: w_seg = 7'h66;
      4'h5: w_seg = 7'h6D;
      4'h6: w_seg = 7'h7D;
      4'h7: w_seg = 7'h07;
      4'h8: w_seg = 7'h7F;
      4'h9: w_seg = 7'h6F;
      4'hA: w_seg = 7'h77;
      4'hB: w_seg = 7'h7C;
      4'hC: w_seg = 7'h39;
      4'hD: w_seg = 7'h5E;
      4'hE: w_seg = 7'h79;
      4'hF: w_seg = 7'h71;
      default: w_seg = 7'h00;
    endcase
  end

  always_comb begin
    w_lz_blank = 1'b0;
    case (w_digit)
      2'd1: w_lz_blank = r_sh_lz && (r_sh_value[15:4] == 12'h000);
      2'd2: w_lz_blank = r_sh_lz && (r_sh_value[15:8] == 8'h00);
      2'd3: w_lz_blank = r_sh_lz && (r_sh_value[15:12] == 4'h0);
      default: w_lz_blank = 1'b0;
    endcase
  end

  always_comb begin
    w_hex_en  = 4'b0000;
    w_hex_led = 8'h00;
    if ((w_state == ST_ON) && !w_lz_blank) begin
      w_hex_en  = 4'b0001 << w_digit;
      w_hex_led = {r_sh_dp[w_digit], w_seg};
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= ST_IDLE;
      r_digit       <= 2'd0;
      r_cnt         <= '0;
      r_sh_value    <= 16'h0000;
      r_sh_dp       <= 4'h0;
      r_sh_lz       <= 1'b0;
      o_load_ack    <= 1'b0;
      o_hex_en      <= 4'b0000;
      o_hex_led     <= 8'h00;
      o_frame_start <= 1'b0;
    end else begin
      r_state       <= w_state;
      r_digit       <= w_digit;
      r_cnt         <= w_cnt;
      o_load_ack    <= w_capture;
      o_hex_en      <= w_hex_en;
      o_hex_led     <= w_hex_led;
      o_frame_start <= w_frame_start;
      if (w_capture) begin
        r_sh_value <= i_value;
        r_sh_dp    <= i_dp;
        r_sh_lz    <= i_blank_lz;
      end
    end
  end

endmodule

// File: tb/tb_hex_scan_ctrl.sv
// tb/tb_hex_scan_ctrl.sv - randomized and directed bench for hex_scan_ctrl against a frame-position model
module tb_hex_scan_ctrl;

  localparam int S     = 8;
  localparam int B     = 2;
  localparam int PER   = S + B;
  localparam int FRAME = 4 * PER;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [15:0] value;
  logic [3:0]  dp;
  logic        blank_lz;
  logic        load;
  logic        load_ack;
  logic [3:0]  hex_en;
  logic [7:0]  hex_led;
  logic        frame_start;

  int checks = 0;
  int errors = 0;

  bit          m_run;
  int          m_p;
  logic [15:0] m_val;
  logic [3:0]  m_dp;
  bit          m_lz;
  bit          m_ack;
  logic [6:0]  seg_tab [16];

  hex_scan_ctrl #(.SLOT_CYCLES(S), .BLANK_CYCLES(B)) dut (
    .i_clk(clk), .i_rst(rst), .i_enable(enable), .i_value(value), .i_dp(dp),
    .i_blank_lz(blank_lz), .i_load(load), .o_load_ack(load_ack), .o_hex_en(hex_en),
    .o_hex_led(hex_led), .o_frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // Model: position within the scan frame, counted in edges since the frame began.
  function automatic logic [13:0] expected();
    logic [3:0]  en;
    logic [7:0]  led;
    logic [15:0] upper;
    int d;
    int w;
    en  = 4'b0000;
    led = 8'h00;
    if (m_run) begin
      d     = m_p / PER;
      w     = m_p % PER;
      upper = m_val >> (4 * d);
      if (w >= B && !(m_lz && d > 0 && upper == 16'h0000)) begin
        en  = 4'(1 << d);
        led = {m_dp[d], seg_tab[upper[3:0]]};
      end
    end
    return {en, led, (m_run && m_p == 0), m_ack};
  endfunction

  function automatic logic [13:0] observed();
    return {hex_en, hex_led, frame_start, load_ack};
  endfunction

  task automatic tick();
    if (!enable) begin
      m_run = 1'b0;
      m_p   = 0;
    end else if (!m_run) begin
      m_run = 1'b1;
      m_p   = 0;
    end else begin
      m_p = (m_p + 1) % FRAME;
    end
    m_ack = load && (!m_run || m_p == 0);
    if (m_ack) begin
      m_val = value;
      m_dp  = dp;
      m_lz  = blank_lz;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1 rst = 1'b1;
    #2;
    checks++;
    if (observed() !== 14'h0) begin
      errors++;
      $display("FAIL reset_async obs=%h exp=%h", observed(), 14'h0);
    end
    @(posedge clk);
    #1;
    checks++;
    if (observed() !== 14'h0) begin
      errors++;
      $display("FAIL reset_edge obs=%h exp=%h", observed(), 14'h0);
    end
    rst = 1'b0;
  endtask

  task automatic test_load_idle();
    value = 16'h1234; dp = 4'h0; blank_lz = 1'b0; load = 1'b1; enable = 1'b0;
    tick();
    checks++;
    if (load_ack !== 1'b1 || hex_en !== 4'b0000 || observed() !== expected()) begin
      errors++;
      $display("FAIL load_idle_ack obs=%h exp=%h", observed(), expected());
    end
    load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (load_ack !== 1'b0 || hex_en !== 4'b0000 || observed() !== expected()) begin
        errors++;
        $display("FAIL load_idle_dark obs=%h exp=%h", observed(), expected());
      end
    end
  endtask

  task automatic test_scan();
    logic [7:0] lit [4] = '{8'h66, 8'h4F, 8'h5B, 8'h06};
    int last_fs = -1;
    int n_fs = 0;
    enable = 1'b1;
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick();
      checks++;
      if (observed() !== expected()) begin
        errors++;
        $display("FAIL scan p=%0d obs=%h exp=%h", m_p, observed(), expected());
      end
      if (m_p % PER == B) begin
        checks++;
        if (hex_en !== 4'(1 << (m_p / PER)) || hex_led !== lit[m_p / PER]) begin
          errors++;
          $display("FAIL scan_digit p=%0d en=%b led=%h want_led=%h", m_p, hex_en, hex_led, lit[m_p / PER]);
        end
      end
      if (frame_start === 1'b1) begin
        n_fs++;
        if (last_fs >= 0) begin
          checks++;
          if (i - last_fs != FRAME) begin
            errors++;
            $display("FAIL frame_period got=%0d want=%0d", i - last_fs, FRAME);
          end
        end
        last_fs = i;
      end
    end
    checks++;
    if (n_fs != 2) begin
      errors++;
      $display("FAIL frame_count got=%0d want=2", n_fs);
    end
  endtask

  task automatic test_lz();
    bit got = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    value = 16'h00A0; blank_lz = 1'b1; dp = 4'b0100; load = 1'b1;
    for (int i = 0; i < 3 * FRAME && !got; i++) begin
      tick();
      checks++;
      if (observed() !== expected()) begin
        errors++;
        $display("FAIL lz_wait p=%0d obs=%h exp=%h", m_p, observed(), expected());
      end
      if (load_ack === 1'b1) begin
        got  = 1'b1;
        load = 1'b0;
        checks++;
        if (frame_start !== 1'b1) begin
          errors++;
          $display("FAIL lz_ack_align frame_start=%b want=1", frame_start);
        end
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL lz_ack_timeout got=0 want=1");
    end
    for (int i = 0; i < FRAME; i++) begin
      tick();
      checks++;
      if (observed() !== expected()) begin
        errors++;
        $display("FAIL lz_frame p=%0d obs=%h exp=%h", m_p, observed(), expected());
      end
      if (m_p == B + PER) begin
        checks++;
        if (hex_en !== 4'b0010 || hex_led !== 8'h77) begin
          errors++;
          $display("FAIL lz_digit1 en=%b led=%h want en=0010 led=77", hex_en, hex_led);
        end
      end
      if (m_p == B + 2 * PER) begin
        checks++;
        if (hex_en !== 4'b0000 || hex_led !== 8'h00) begin
          errors++;
          $display("FAIL lz_digit2 en=%b led=%h want en=0000 led=00", hex_en, hex_led);
        end
      end
    end
  endtask

  task automatic test_midload();
    bit got = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    value = 16'hFFFF; blank_lz = 1'b0; dp = 4'h0; load = 1'b1;
    for (int i = 0; i < 3 * FRAME && !got; i++) begin
      tick();
      checks++;
      if (observed() !== expected()) begin
        errors++;
        $display("FAIL mid_wait p=%0d obs=%h exp=%h", m_p, observed(), expected());
      end
      if (m_p == B + PER && !m_ack) begin
        checks++;
        if (hex_led !== 8'h77) begin
          errors++;
          $display("FAIL mid_old_data led=%h want=77", hex_led);
        end
      end
      if (load_ack === 1'b1) begin
        got  = 1'b1;
        load = 1'b0;
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL mid_ack_timeout got=0 want=1");
    end
    for (int i = 0; i < FRAME; i++) begin
      tick();
      if (m_p % PER == B) begin
        checks++;
        if (hex_led !== 8'h71 || hex_en !== 4'(1 << (m_p / PER))) begin
          errors++;
          $display("FAIL mid_new_data p=%0d en=%b led=%h want led=71", m_p, hex_en, hex_led);
        end
      end
    end
  endtask

  task automatic test_enable_drop();
    for (int i = 0; i < 2 * FRAME && m_p != B + 2 * PER + 3; i++) tick();
    checks++;
    if (hex_en !== 4'b0100) begin
      errors++;
      $display("FAIL drop_pre en=%b want=0100", hex_en);
    end
    enable = 1'b0;
    tick();
    checks++;
    if (observed() !== 14'h0 || observed() !== expected()) begin
      errors++;
      $display("FAIL drop_dark obs=%h exp=%h", observed(), expected());
    end
    tick();
    enable = 1'b1;
    tick();
    checks++;
    if (frame_start !== 1'b1 || hex_en !== 4'b0000) begin
      errors++;
      $display("FAIL drop_restart frame_start=%b en=%b want 1 0000", frame_start, hex_en);
    end
    for (int i = 0; i < PER; i++) begin
      tick();
      checks++;
      if (observed() !== expected()) begin
        errors++;
        $display("FAIL drop_rescan p=%0d obs=%h exp=%h", m_p, observed(), expected());
      end
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 2 * FRAME && m_p != B + PER + 3; i++) tick();
    #2 rst = 1'b1;
    #1;
    checks++;
    if (observed() !== 14'h0) begin
      errors++;
      $display("FAIL areset_now obs=%h exp=%h", observed(), 14'h0);
    end
    m_run = 1'b0; m_p = 0; m_val = 16'h0; m_dp = 4'h0; m_lz = 1'b0; m_ack = 1'b0;
    #2 rst = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick();
      checks++;
      if (observed() !== expected()) begin
        errors++;
        $display("FAIL areset_scan p=%0d obs=%h exp=%h", m_p, observed(), expected());
      end
      if (m_p == B) begin
        checks++;
        if (hex_led !== 8'h3F || hex_en !== 4'b0001) begin
          errors++;
          $display("FAIL areset_shadow led=%h en=%b want 3F 0001", hex_led, hex_en);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      enable   = ($urandom_range(0, 39) != 0);
      load     = ($urandom_range(0, 3) == 0);
      value    = 16'($urandom);
      dp       = 4'($urandom);
      blank_lz = 1'($urandom);
      if ($urandom_range(0, 2) == 0) value[15:8] = 8'h00;
      tick();
      checks++;
      if (observed() !== expected()) begin
        errors++;
        $display("FAIL random i=%0d p=%0d obs=%h exp=%h", i, m_p, observed(), expected());
      end
    end
  endtask

  initial begin
    seg_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    m_run = 1'b0; m_p = 0; m_val = 16'h0; m_dp = 4'h0; m_lz = 1'b0; m_ack = 1'b0;
    enable = 1'b0; value = 16'h0; dp = 4'h0; blank_lz = 1'b0; load = 1'b0;
    test_reset();
    test_load_idle();
    test_scan();
    test_lz();
    test_midload();
    test_enable_drop();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
